id_ex_stage: RTL and testbench

ID/EX pipeline stage of the ARMv8 pipeline. It sits directly upstream of the ALU and captures the decoded operands and control bits of one instruction per clock. It generates the ALU's 4-bit mode and its two 64-bit operands, and it implements stall (hold), flush (bubble insertion) and illegal-opcode squashing. Outputs drive the ALU inputs and the EX/MEM control path.

---
 rtl/id_ex_stage.sv | 166 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the ARMv8 pipeline.
// Decodes the ALU mode and operands, then registers them with the EX/MEM
// control bits. Supports stall (hold), flush (bubble) and illegal squashing.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [10:0] opcode,
    input  logic [4:0]  rd,
    input  logic [63:0] rn_data,
    input  logic [63:0] rm_data,
    input  logic [63:0] imm,
    input  logic        alu_src,
    input  logic        reg_write,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_to_reg,
    input  logic        branch,
    input  logic [1:0]  alu_op,
    output logic        ex_valid,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    output logic [3:0]  alu_mode,
    output logic [4:0]  ex_rd,
    output logic [63:0] ex_store_data,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_mem_to_reg,
    output logic        ex_branch,
    output logic        illegal
);

    // All pipeline state in one record so a bubble is a single all-zero value.
    typedef struct packed {
        logic        valid;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  mode;
        logic [4:0]  rd;
        logic [63:0] store_data;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        branch;
    } ex_regs_t;

    localparam ex_regs_t BUBBLE = '0;

    localparam logic [3:0] MODE_AND  = 4'b0000;
    localparam logic [3:0] MODE_OR   = 4'b0001;
    localparam logic [3:0] MODE_ADD  = 4'b0010;
    localparam logic [3:0] MODE_LSL  = 4'b0011;
    localparam logic [3:0] MODE_LSR  = 4'b0100;
    localparam logic [3:0] MODE_SUB  = 4'b0110;
    localparam logic [3:0] MODE_PASB = 4'b0111;

    // Returns {legal, shift, mode[3:0]} for a main-control class and opcode.
    function automatic logic [5:0] decode_alu(input logic [1:0] op, input logic [10:0] opc);
        logic [5:0] r;
        r = {1'b0, 1'b0, 4'b0000};
        case (op)
            2'b00: r = {1'b1, 1'b0, MODE_ADD};
            2'b01: r = {1'b1, 1'b0, MODE_PASB};
            2'b10: begin
                case (opc)
                    11'b10001011000: r = {1'b1, 1'b0, MODE_ADD};
                    11'b11001011000: r = {1'b1, 1'b0, MODE_SUB};
                    11'b10001010000: r = {1'b1, 1'b0, MODE_AND};
                    11'b10101010000: r = {1'b1, 1'b0, MODE_OR};
                    11'b11010011011: r = {1'b1, 1'b1, MODE_LSL};
                    11'b11010011010: r = {1'b1, 1'b1, MODE_LSR};
                    default:         r = {1'b0, 1'b0, 4'b0000};
                endcase
            end
            2'b11: begin
                case (opc[10:1])
                    10'b1001000100: r = {1'b1, 1'b0, MODE_ADD};
                    10'b1101000100: r = {1'b1, 1'b0, MODE_SUB};
                    default:        r = {1'b0, 1'b0, 4'b0000};
                endcase
            end
            default: r = {1'b0, 1'b0, 4'b0000};
        endcase
        return r;
    endfunction

    ex_regs_t ex_q;
    ex_regs_t ex_d;
    ex_regs_t load_s;
    logic     illegal_q;
    logic     illegal_d;
    logic     legal_s;
    logic     shift_s;
    logic [3:0] mode_s;

    // Decode the incoming instruction into the record it would load.
    always_comb begin
        {legal_s, shift_s, mode_s} = decode_alu(alu_op, opcode);
        load_s            = BUBBLE;
        load_s.valid      = 1'b1;
        load_s.a          = rn_data;
        load_s.mode       = mode_s;
        load_s.rd         = rd;
        load_s.store_data = rm_data;
        load_s.reg_write  = reg_write;
        load_s.mem_read   = mem_read;
        load_s.mem_write  = mem_write;
        load_s.mem_to_reg = mem_to_reg;
        load_s.branch     = branch;
        if (shift_s) begin
            // Shifts take their amount from the immediate's shamt field only.
            load_s.b = {58'd0, imm[5:0]};
        end else if (alu_src) begin
            load_s.b = imm;
        end else begin
            load_s.b = rm_data;
        end
    end

    // Next-state priority: flush, stall, empty slot, illegal squash, load.
    always_comb begin
        ex_d      = ex_q;
        illegal_d = 1'b0;
        if (flush) begin
            ex_d = BUBBLE;
        end else if (stall) begin
            ex_d = ex_q;
        end else if (!in_valid) begin
            ex_d = BUBBLE;
        end else if (!legal_s) begin
            ex_d      = BUBBLE;
            illegal_d = 1'b1;
        end else begin
            ex_d = load_s;
        end
    end

    // Pipeline registers with synchronous active-low reset to the bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q      <= BUBBLE;
            illegal_q <= 1'b0;
        end else begin
            ex_q      <= ex_d;
            illegal_q <= illegal_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign alu_a         = ex_q.a;
    assign alu_b         = ex_q.b;
    assign alu_mode      = ex_q.mode;
    assign ex_rd         = ex_q.rd;
    assign ex_store_data = ex_q.store_data;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_branch     = ex_q.branch;
    assign illegal       = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage with a queue-based scoreboard.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, in_valid;
    logic [10:0] opcode;
    logic [4:0]  rd;
    logic [63:0] rn_data, rm_data, imm;
    logic        alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch;
    logic [1:0]  alu_op;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, illegal;
    logic [63:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_mode;
    logic [4:0]  ex_rd;

    typedef struct {
        logic        valid;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  mode;
        logic [4:0]  rd;
        logic [63:0] sd;
        logic [4:0]  ctl;   // {reg_write, mem_read, mem_write, mem_to_reg, branch}
        logic        ill;
    } exp_t;

    exp_t q_exp[$];
    exp_t mdl;
    int   errors = 0;
    int   checks = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
        .opcode(opcode), .rd(rd), .rn_data(rn_data), .rm_data(rm_data), .imm(imm),
        .alu_src(alu_src), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .branch(branch), .alu_op(alu_op),
        .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .ex_rd(ex_rd),
        .ex_store_data(ex_store_data), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic exp_t bubble();
        exp_t e;
        e.valid = 1'b0; e.a = 64'd0; e.b = 64'd0; e.mode = 4'd0;
        e.rd = 5'd0; e.sd = 64'd0; e.ctl = 5'd0; e.ill = 1'b0;
        return e;
    endfunction

    // Reference behaviour derived from the mode/operand tables.
    function automatic exp_t model();
        exp_t e;
        logic ok;
        logic sh;
        logic [3:0] m;
        ok = 1'b1; sh = 1'b0; m = 4'd0;
        e = bubble();
        if (!rst_n || flush) return e;
        if (stall) begin
            e = mdl; e.ill = 1'b0; return e;
        end
        if (!in_valid) return e;
        if (alu_op == 2'b00) m = 4'b0010;
        else if (alu_op == 2'b01) m = 4'b0111;
        else if (alu_op == 2'b10) begin
            if      (opcode == 11'b10001011000) m = 4'b0010;
            else if (opcode == 11'b11001011000) m = 4'b0110;
            else if (opcode == 11'b10001010000) m = 4'b0000;
            else if (opcode == 11'b10101010000) m = 4'b0001;
            else if (opcode == 11'b11010011011) begin m = 4'b0011; sh = 1'b1; end
            else if (opcode == 11'b11010011010) begin m = 4'b0100; sh = 1'b1; end
            else ok = 1'b0;
        end else begin
            if      (opcode[10:1] == 10'b1001000100) m = 4'b0010;
            else if (opcode[10:1] == 10'b1101000100) m = 4'b0110;
            else ok = 1'b0;
        end
        if (!ok) begin
            e.ill = 1'b1; return e;
        end
        e.valid = 1'b1; e.a = rn_data; e.mode = m; e.rd = rd; e.sd = rm_data;
        e.b = sh ? (imm & 64'h3F) : (alu_src ? imm : rm_data);
        e.ctl = {reg_write, mem_read, mem_write, mem_to_reg, branch};
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Push the expectation for the current inputs, clock once, pop and compare.
    task automatic step();
        exp_t e;
        e = model();
        mdl = e;
        q_exp.push_back(e);
        @(posedge clk);
        #1;
        e = q_exp.pop_front();
        chk("ex_valid", {63'd0, ex_valid}, {63'd0, e.valid});
        chk("alu_a", alu_a, e.a);
        chk("alu_b", alu_b, e.b);
        chk("alu_mode", {60'd0, alu_mode}, {60'd0, e.mode});
        chk("ex_rd", {59'd0, ex_rd}, {59'd0, e.rd});
        chk("ex_store_data", ex_store_data, e.sd);
        chk("ex_ctl", {59'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch},
            {59'd0, e.ctl});
        chk("illegal", {63'd0, illegal}, {63'd0, e.ill});
    endtask

    task automatic rand_inputs();
        stall = 1'($urandom); flush = 1'($urandom); in_valid = 1'($urandom);
        opcode = 11'($urandom); rd = 5'($urandom);
        rn_data = {$urandom, $urandom}; rm_data = {$urandom, $urandom}; imm = {$urandom, $urandom};
        {alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch} = 6'($urandom);
        alu_op = 2'($urandom);
    endtask

    task automatic idle();
        stall = 1'b0; flush = 1'b0; in_valid = 1'b0; opcode = 11'd0; rd = 5'd0;
        rn_data = 64'd0; rm_data = 64'd0; imm = 64'd0;
        {alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch} = 6'd0; alu_op = 2'b00;
    endtask

    task automatic instr(input logic [1:0] op, input logic [10:0] opc, input logic [4:0] d,
                         input logic [63:0] rn, input logic [63:0] rm, input logic [63:0] im,
                         input logic src, input logic [4:0] ctl);
        in_valid = 1'b1; alu_op = op; opcode = opc; rd = d;
        rn_data = rn; rm_data = rm; imm = im; alu_src = src;
        {reg_write, mem_read, mem_write, mem_to_reg, branch} = ctl;
    endtask

    initial begin
        mdl = bubble();
        rst_n = 1'b0;
        rand_inputs(); step();
        rand_inputs(); step();
        // Explicit reset values independent of the model.
        chk("reset_valid", {63'd0, ex_valid}, 64'd0);
        chk("reset_mode", {60'd0, alu_mode}, 64'd0);
        chk("reset_a", alu_a, 64'd0);
        chk("reset_b", alu_b, 64'd0);
        chk("reset_illegal", {63'd0, illegal}, 64'd0);
        rst_n = 1'b1;
        idle();
        step();

        // R-type SUB
        instr(2'b10, 11'b11001011000, 5'd5, 64'd10, 64'd3, 64'd99, 1'b0, 5'b10000);
        step();
        chk("sub_mode", {60'd0, alu_mode}, 64'h6);
        chk("sub_b", alu_b, 64'd3);
        // LSL: shamt from imm[5:0]
        instr(2'b10, 11'b11010011011, 5'd7, 64'd1, 64'hFFFF, 64'h44, 1'b0, 5'b10000);
        step();
        chk("lsl_b", alu_b, 64'd4);
        chk("lsl_mode", {60'd0, alu_mode}, 64'h3);
        // LSR, AND, OR
        instr(2'b10, 11'b11010011010, 5'd8, 64'hF0, 64'h1, 64'hFFFF_FFFF_FFFF_FFC5, 1'b0, 5'b10000);
        step();
        instr(2'b10, 11'b10001010000, 5'd9, 64'hFF00, 64'h0FF0, 64'd0, 1'b0, 5'b10000);
        step();
        instr(2'b10, 11'b10101010000, 5'd10, 64'h1, 64'h2, 64'd0, 1'b0, 5'b10000);
        step();
        // ADDI with imm = -1
        instr(2'b11, 11'b10010001000, 5'd11, 64'd20, 64'h55, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'b10000);
        step();
        chk("addi_b", alu_b, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_mode", {60'd0, alu_mode}, 64'h2);
        // SUBI (low opcode bit ignored)
        instr(2'b11, 11'b11010001001, 5'd12, 64'd20, 64'h55, 64'd4, 1'b1, 5'b10000);
        step();

        // STUR then stall 3 cycles with changing inputs
        instr(2'b00, 11'b11111000000, 5'd3, 64'h1000, 64'hAB, 64'd8, 1'b1, 5'b00100);
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr(2'b10, 11'($urandom), 5'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, 1'($urandom), 5'($urandom));
            step();
            chk("stall_sd", ex_store_data, 64'hAB);
        end
        flush = 1'b1;
        step();
        chk("flush_valid", {63'd0, ex_valid}, 64'd0);
        idle();

        // Illegal then legal ADD
        instr(2'b10, 11'b11111111111, 5'd4, 64'd1, 64'd2, 64'd0, 1'b0, 5'b10000);
        step();
        chk("ill_pulse", {63'd0, illegal}, 64'd1);
        instr(2'b10, 11'b10001011000, 5'd4, 64'd1, 64'd2, 64'd0, 1'b0, 5'b10000);
        step();
        chk("ill_clear", {63'd0, illegal}, 64'd0);
        chk("add_valid", {63'd0, ex_valid}, 64'd1);
        // Illegal I-type, then stall: illegal must drop
        instr(2'b11, 11'b00000000000, 5'd4, 64'd1, 64'd2, 64'd0, 1'b1, 5'b10000);
        step();
        stall = 1'b1;
        step();
        stall = 1'b0;

        // CBZ
        instr(2'b01, 11'b10110100000, 5'd0, 64'd77, 64'd0, 64'd16, 1'b0, 5'b00001);
        step();
        chk("cbz_mode", {60'd0, alu_mode}, 64'h7);
        chk("cbz_branch", {63'd0, ex_branch}, 64'd1);
        // Empty slot
        in_valid = 1'b0;
        step();
        // Reset during stall+flush
        instr(2'b00, 11'd0, 5'd2, 64'd5, 64'd6, 64'd7, 1'b1, 5'b01010);
        step();
        stall = 1'b1; flush = 1'b1; rst_n = 1'b0;
        step();
        rst_n = 1'b1; idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
